// File: rtl/lcd_rgb_rx.sv
// RGB LCD receiver in DE mode: recovers pixels and x/y coordinates, measures frame geometry and flags lock.
// Optional per-frame pixel checksum output frame_sum is built when LCD_RX_CHECKSUM_EN is defined.
module lcd_rgb_rx #(
  parameter int GAP_THRESH = 2048
) (
  input  logic        lcd_pclk,
  input  logic        rst_n,
  input  logic        lcd_de,
  input  logic [15:0] lcd_rgb,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [10:0] pix_xpos,
  output logic [10:0] pix_ypos,
  output logic        frame_start,
  output logic        frame_done,
  output logic [10:0] h_disp_meas,
  output logic [10:0] v_disp_meas,
  output logic        locked,
  output logic        geom_err
`ifdef LCD_RX_CHECKSUM_EN
  ,
  output logic [15:0] frame_sum
`endif
);

  localparam int GW = $clog2(GAP_THRESH + 1);
  localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_THRESH);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_THRESH - 1);
  localparam logic [10:0]   CMAX     = 11'd2047;

  typedef enum logic [1:0] {SEARCH, VBLANK, ACTIVE} state_t;

  state_t        state_q;
  logic [GW-1:0] gap_cnt_q;
  logic          de_q;
  logic [10:0]   y_q;
  logic [10:0]   lw_q;
  logic [10:0]   ref_q;
  logic          ref_vld_q;
  logic          pix_valid_q;
  logic [15:0]   pix_data_q;
  logic [10:0]   pix_xpos_q;
  logic [10:0]   pix_ypos_q;
  logic          frame_start_q;
  logic          frame_done_q;
  logic [10:0]   h_meas_q;
  logic [10:0]   v_meas_q;
  logic          locked_q;
  logic          geom_err_q;
`ifdef LCD_RX_CHECKSUM_EN
  logic [15:0]   sum_acc_q;
  logic [15:0]   frame_sum_q;
`endif

  logic        gap_evt;
  logic        de_rise;
  logic        de_fall;
  logic        mismatch;
  logic        geom_d;
  logic [10:0] h_d;
  logic [10:0] v_d;
  logic [10:0] y_inc;
  logic [10:0] x_inc;
  logic [10:0] lw_inc;

  // gap_cnt saturates at GAP_THRESH, so it hits GAP_LAST on a low sample only once per gap
  always_comb begin
    gap_evt  = !lcd_de && (gap_cnt_q == GAP_LAST);
    de_rise  = lcd_de && !de_q;
    de_fall  = !lcd_de && de_q;
    mismatch = de_fall && ref_vld_q && (lw_q != ref_q);
    geom_d   = geom_err_q || mismatch;
    // a fall coinciding with the gap event (tiny thresholds) still yields a reference
    h_d      = ref_vld_q ? ref_q : lw_q;
    v_d      = (y_q == CMAX) ? CMAX : y_q + 11'd1;
    y_inc    = (y_q == CMAX) ? CMAX : y_q + 11'd1;
    x_inc    = (pix_xpos_q == CMAX) ? CMAX : pix_xpos_q + 11'd1;
    lw_inc   = (lw_q == CMAX) ? CMAX : lw_q + 11'd1;
  end

  always_ff @(posedge lcd_pclk) begin
    if (!rst_n) begin
      state_q       <= SEARCH;
      gap_cnt_q     <= '0;
      de_q          <= 1'b0;
      y_q           <= '0;
      lw_q          <= '0;
      ref_q         <= '0;
      ref_vld_q     <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_xpos_q    <= '0;
      pix_ypos_q    <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      h_meas_q      <= '0;
      v_meas_q      <= '0;
      locked_q      <= 1'b0;
      geom_err_q    <= 1'b0;
`ifdef LCD_RX_CHECKSUM_EN
      sum_acc_q     <= '0;
      frame_sum_q   <= '0;
`endif
    end else begin
      de_q <= lcd_de;
      if (lcd_de)
        gap_cnt_q <= '0;
      else if (gap_cnt_q != GAP_MAX)
        gap_cnt_q <= gap_cnt_q + 1'b1;

      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_xpos_q    <= '0;
      pix_ypos_q    <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;

      case (state_q)
        SEARCH: begin
          if (gap_evt) state_q <= VBLANK;
        end
        VBLANK: begin
          if (lcd_de) begin
            state_q       <= ACTIVE;
            frame_start_q <= 1'b1;
            pix_valid_q   <= 1'b1;
            pix_data_q    <= lcd_rgb;
            y_q           <= '0;
            lw_q          <= 11'd1;
            ref_vld_q     <= 1'b0;
            geom_err_q    <= 1'b0;
`ifdef LCD_RX_CHECKSUM_EN
            sum_acc_q     <= lcd_rgb;
`endif
          end
        end
        ACTIVE: begin
          if (lcd_de) begin
            pix_valid_q <= 1'b1;
            pix_data_q  <= lcd_rgb;
`ifdef LCD_RX_CHECKSUM_EN
            sum_acc_q   <= sum_acc_q + lcd_rgb;
`endif
            if (de_rise) begin
              y_q        <= y_inc;
              pix_ypos_q <= y_inc;
              lw_q       <= 11'd1;
            end else begin
              pix_xpos_q <= x_inc;
              pix_ypos_q <= y_q;
              lw_q       <= lw_inc;
            end
          end else begin
            if (de_fall && !ref_vld_q) begin
              ref_q     <= lw_q;
              ref_vld_q <= 1'b1;
            end
            geom_err_q <= geom_d;
            if (gap_evt) begin
              state_q      <= VBLANK;
              frame_done_q <= 1'b1;
              h_meas_q     <= h_d;
              v_meas_q     <= v_d;
              locked_q     <= (h_d == h_meas_q) && (v_d == v_meas_q) && !geom_d;
`ifdef LCD_RX_CHECKSUM_EN
              frame_sum_q  <= sum_acc_q;
`endif
            end
          end
        end
        default: state_q <= SEARCH;
      endcase
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_xpos    = pix_xpos_q;
  assign pix_ypos    = pix_ypos_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign h_disp_meas = h_meas_q;
  assign v_disp_meas = v_meas_q;
  assign locked      = locked_q;
  assign geom_err    = geom_err_q;
`ifdef LCD_RX_CHECKSUM_EN
  assign frame_sum   = frame_sum_q;
`endif

endmodule
